// File: rtl/mio_ram_arbiter_if.sv
// Two-master request/response bundle for the MIO RAM data-port arbiter.
// Names match the arbiter's master-side pin list.
interface mio_ram_arbiter_if;
  logic        req0,   req1;
  logic        we0,    we1;
  logic        lock0,  lock1;
  logic [31:0] addr0,  addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0,   gnt1;
  logic        ack0,   ack1;
  logic [31:0] rdata0, rdata1;
  logic        err0,   err1;

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, ack0, ack1, rdata0, rdata1, err0, err1
  );

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, ack0, ack1, rdata0, rdata1, err0, err1
  );
endinterface

// File: rtl/mio_ram_arbiter.sv
// Round-robin arbiter sharing the MIO RAM data port between CPU (port 0) and loader (port 1).
// Optional feature: define MIO_ARB_RANGE_EN to flag/suppress beats with addr[31:10] != 0.

module mio_ram_arbiter_port (
  input  logic        own,
  input  logic        req,
  input  logic        we,
  input  logic        range_bad,
  input  logic [31:0] d_f_ram,
  output logic        ack,
  output logic        err,
  output logic        wr,
  output logic [31:0] rdata
);
  // Out-of-range beats are still acked so the master moves on, but never touch RAM.
  assign ack   = own & req;
  assign err   = ack & range_bad;
  assign wr    = ack & we & ~range_bad;
  assign rdata = (ack & ~range_bad) ? d_f_ram : 32'h0;
endmodule

module mio_ram_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                clrn,
  mio_ram_arbiter_if.slave    bus,
  output logic [31:0]         ram_a,
  output logic [31:0]         d_t_ram,
  output logic                wram,
  input  logic [31:0]         d_f_ram
);
  localparam int NP = 2;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e            state_q, state_d;
  logic              last_q,  last_d;
  logic [CNT_W-1:0]  hold_q,  hold_d;

  logic [NP-1:0]        req, we, lock, own, ack, err, wr, range_bad;
  logic [NP-1:0][31:0]  addr, wdata, rdata;

  assign req   = {bus.req1,   bus.req0};
  assign we    = {bus.we1,    bus.we0};
  assign lock  = {bus.lock1,  bus.lock0};
  assign addr  = {bus.addr1,  bus.addr0};
  assign wdata = {bus.wdata1, bus.wdata0};

  assign own = {state_q == OWN1, state_q == OWN0};

  generate
    for (genvar p = 0; p < NP; p++) begin : g_port
`ifdef MIO_ARB_RANGE_EN
      assign range_bad[p] = |addr[p][31:10];
`else
      assign range_bad[p] = 1'b0;
`endif
      mio_ram_arbiter_port u_port (
        .own       (own[p]),
        .req       (req[p]),
        .we        (we[p]),
        .range_bad (range_bad[p]),
        .d_f_ram   (d_f_ram),
        .ack       (ack[p]),
        .err       (err[p]),
        .wr        (wr[p]),
        .rdata     (rdata[p])
      );
    end
  endgenerate

  assign bus.gnt0   = own[0];
  assign bus.gnt1   = own[1];
  assign bus.ack0   = ack[0];
  assign bus.ack1   = ack[1];
  assign bus.err0   = err[0];
  assign bus.err1   = err[1];
  assign bus.rdata0 = rdata[0];
  assign bus.rdata1 = rdata[1];

  always_comb begin
    ram_a   = 32'h0;
    d_t_ram = 32'h0;
    if (own[0]) begin
      ram_a   = addr[0];
      d_t_ram = wdata[0];
    end else if (own[1]) begin
      ram_a   = addr[1];
      d_t_ram = wdata[1];
    end
  end

  // Gating with clrn kills an in-flight write before the negedge commit.
  assign wram = (|wr) & clrn;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (req[0] && req[1])  state_d = last_q ? OWN0 : OWN1;
        else if (req[0])       state_d = OWN0;
        else if (req[1])       state_d = OWN1;
      end
      OWN0: begin
        if (!req[0])                                         state_d = req[1] ? OWN1 : IDLE;
        else if (req[1] && !lock[0] && hold_q == HOLD_LAST)  state_d = OWN1;
      end
      OWN1: begin
        if (!req[1])                                         state_d = req[0] ? OWN0 : IDLE;
        else if (req[0] && !lock[1] && hold_q == HOLD_LAST)  state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase

    // Counter saturates at the hold limit so a lock release hands over on the very next beat.
    if (state_d != state_q) begin
      hold_d = '0;
      if (state_d == OWN0)      last_d = 1'b0;
      else if (state_d == OWN1) last_d = 1'b1;
    end else if ((|ack) && hold_q != HOLD_LAST) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end
endmodule
